ycbcr422_demux: RTL

- Receive-side counterpart of the 4:2:2 luma/chroma interleaver.
- Accepts a 20-bit stream of {Y, C} words in which the chroma field alternates Cb, Cr. Cb is carried on even pixels and Cr on odd pixels.
- Reconstructs full 4:4:4 pixels, {Y, Cb, Cr} per cycle, by replicating each chroma pair across its two pixels.
- Sits between the video input interface and downstream colour-space and processing blocks. Includes line-phase locking and framing-error detection.

---
 rtl/ycbcr422_demux.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/ycbcr422_demux.sv
// ---------------------------------------------------------------------------
// ycbcr422_demux
//   Receive-side 4:2:2 -> 4:4:4 chroma demultiplexer. Accepts a stream of
//   {Y, C} words where C alternates Cb (even pixel) and Cr (odd pixel), and
//   emits one full {Y, Cb, Cr} pixel per cycle. Each chroma pair is copied
//   onto both pixels of its pair. Includes line-phase locking on in_sol and
//   detection of orphan even words (framing errors).
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : in_data carries a word this cycle
//   in_sol     : start of line, marks an even (Cb) word
//   in_data    : {Y[2DW-1:DW], C[DW-1:0]}
//   out_valid  : out_* carries a pixel this cycle
//   out_sol    : first pixel of a line
//   out_luma   : Y
//   out_cb     : Cb
//   out_cr     : Cr
//   err_pulse  : one-cycle framing-error strobe
//   err_count  : saturating framing-error count
// ---------------------------------------------------------------------------
module ycbcr422_demux #(
  parameter int DW   = 10,
  parameter int ERRW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  input  logic            in_sol,
  input  logic [2*DW-1:0] in_data,
  output logic            out_valid,
  output logic            out_sol,
  output logic [DW-1:0]   out_luma,
  output logic [DW-1:0]   out_cb,
  output logic [DW-1:0]   out_cr,
  output logic            err_pulse,
  output logic [ERRW-1:0] err_count
);

  localparam logic [0:0] EVEN = 1'b0;
  localparam logic [0:0] ODD  = 1'b1;

  logic [0:0]    phase;
  logic          locked;

  // Even-word capture; overwritten freely by the next line's even word.
  logic [DW-1:0] even_y;
  logic [DW-1:0] even_cb;
  logic          even_sol;

  // Completed pair. Kept separate from the even capture so that a new even
  // word accepted while pixel1 is still pending cannot corrupt pixel1.
  logic [DW-1:0] pair_y0;
  logic [DW-1:0] pair_y1;
  logic [DW-1:0] pair_cb;
  logic [DW-1:0] pair_cr;
  logic          pair_sol;

  logic          pend0;
  logic          pend1;

  logic [DW-1:0] in_y;
  logic [DW-1:0] in_c;
  logic          accept;
  logic          orphan;

  assign in_y   = in_data[2*DW-1:DW];
  assign in_c   = in_data[DW-1:0];
  // Until the first start-of-line, words without in_sol are dropped.
  assign accept = in_valid && (locked || in_sol);
  // An in_sol while waiting for the odd word leaves an orphan even word.
  assign orphan = accept && in_sol && (phase == ODD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase     <= EVEN;
      locked    <= 1'b0;
      even_y    <= '0;
      even_cb   <= '0;
      even_sol  <= 1'b0;
      pair_y0   <= '0;
      pair_y1   <= '0;
      pair_cb   <= '0;
      pair_cr   <= '0;
      pair_sol  <= 1'b0;
      pend0     <= 1'b0;
      pend1     <= 1'b0;
      out_valid <= 1'b0;
      out_sol   <= 1'b0;
      out_luma  <= '0;
      out_cb    <= '0;
      out_cr    <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      // Emission: pixel0 the cycle after the pair completes, pixel1 the
      // cycle after that regardless of input activity.
      if (pend0) begin
        out_valid <= 1'b1;
        out_sol   <= pair_sol;
        out_luma  <= pair_y0;
        out_cb    <= pair_cb;
        out_cr    <= pair_cr;
        pend0     <= 1'b0;
        pend1     <= 1'b1;
      end else if (pend1) begin
        out_valid <= 1'b1;
        out_sol   <= 1'b0;
        out_luma  <= pair_y1;
        out_cb    <= pair_cb;
        out_cr    <= pair_cr;
        pend1     <= 1'b0;
      end else begin
        out_valid <= 1'b0;
        out_sol   <= 1'b0;
      end

      // Input side. A start-of-line word is always handled as an even word,
      // which both realigns the phase and discards any orphan.
      if (accept) begin
        locked <= 1'b1;
        if (in_sol || (phase == EVEN)) begin
          even_y   <= in_y;
          even_cb  <= in_c;
          even_sol <= in_sol;
          phase    <= ODD;
        end else begin
          pair_y0  <= even_y;
          pair_cb  <= even_cb;
          pair_sol <= even_sol;
          pair_y1  <= in_y;
          pair_cr  <= in_c;
          pend0    <= 1'b1;
          phase    <= EVEN;
        end
      end

      err_pulse <= orphan;
      if (orphan && (err_count != '1)) begin
        err_count <= err_count + ERRW'(1);
      end
    end
  end

endmodule
